// File: rtl/cmd_cfg_master_if.sv
// -----------------------------------------------------------------------------
// cmd_cfg_master_if
// Groups the command/response signals of cmd_cfg_master.
//   master modport : the cmd_cfg_master block itself
//                    in : send_cmd, cmd_data[23:0], RX, clr_rsp_rdy
//                    out: TX, tx_busy, tx_done, rsp_data[15:0], rsp_rdy, frm_err
//   slave modport  : the user/device side (mirror image of master)
// -----------------------------------------------------------------------------
interface cmd_cfg_master_if;
  logic        send_cmd;
  logic [23:0] cmd_data;
  logic        TX;
  logic        RX;
  logic        clr_rsp_rdy;
  logic        tx_busy;
  logic        tx_done;
  logic [15:0] rsp_data;
  logic        rsp_rdy;
  logic        frm_err;

  modport master (
    input  send_cmd, cmd_data, RX, clr_rsp_rdy,
    output TX, tx_busy, tx_done, rsp_data, rsp_rdy, frm_err
  );

  modport slave (
    output send_cmd, cmd_data, RX, clr_rsp_rdy,
    input  TX, tx_busy, tx_done, rsp_data, rsp_rdy, frm_err
  );
endinterface

// File: rtl/cmd_cfg_master.sv
// -----------------------------------------------------------------------------
// cmd_cfg_master
// Sends a 3-byte command packet (8N1, MSB byte first) on TX and collects a
// 2-byte response from RX. TX and RX paths are independent.
// Parameters:
//   BAUD_DIV : clocks per bit (8..4095)
//   GAP_BITS : idle bit-times allowed after response byte 0
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : cmd_cfg_master_if.master (send_cmd, cmd_data, TX, RX, clr_rsp_rdy,
//          tx_busy, tx_done, rsp_data, rsp_rdy, frm_err)
// -----------------------------------------------------------------------------
module cmd_cfg_master #(
  parameter int BAUD_DIV = 868,
  parameter int GAP_BITS = 20
) (
  input  logic               clk,
  input  logic               rst,
  cmd_cfg_master_if.master   bus
);

  localparam int             HALF      = BAUD_DIV / 2;
  localparam int             GAP_CLKS  = GAP_BITS * BAUD_DIV;
  localparam int             GW        = $clog2(GAP_CLKS + 1);
  localparam logic [11:0]    BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0]    HALF_LAST = 12'(HALF - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_CLKS - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [11:0] tx_baud_q, tx_baud_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [1:0]  tx_byte_q, tx_byte_d;
  logic [23:0] tx_data_q, tx_data_d;
  logic        tx_line_q, tx_line_d;
  logic        tx_done_q, tx_done_d;
  logic [7:0]  tx_next_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_data_q  <= '0;
      tx_line_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_data_q  <= tx_data_d;
      tx_line_q  <= tx_line_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_baud_d    = tx_baud_q;
    tx_bit_d     = tx_bit_q;
    tx_byte_d    = tx_byte_q;
    tx_data_d    = tx_data_q;
    tx_done_d    = 1'b0;
    tx_line_d    = 1'b1;
    tx_next_byte = 8'h00;

    case (tx_state_q)
      TX_IDLE: begin
        // Data is only captured here, so requests during a packet are ignored.
        if (bus.send_cmd) begin
          tx_data_d  = bus.cmd_data;
          tx_state_d = TX_START;
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_byte_d  = '0;
        end
      end
      TX_START: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_baud_d = tx_baud_q + 12'd1;
        end
      end
      TX_DATA: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_baud_d = tx_baud_q + 12'd1;
        end
      end
      TX_STOP: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          if (tx_byte_q == 2'd2) begin
            tx_state_d = TX_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no idle time.
            tx_byte_d  = tx_byte_q + 2'd1;
            tx_state_d = TX_START;
          end
        end else begin
          tx_baud_d = tx_baud_q + 12'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // The line is registered from the next-state values so TX, tx_busy and
    // tx_done all change on the same clock edge.
    case (tx_byte_d)
      2'd0:    tx_next_byte = tx_data_d[23:16];
      2'd1:    tx_next_byte = tx_data_d[15:8];
      default: tx_next_byte = tx_data_d[7:0];
    endcase

    case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_next_byte[tx_bit_d];
      default:  tx_line_d = 1'b1;
    endcase
  end

  assign bus.TX      = tx_line_q;
  assign bus.tx_busy = (tx_state_q != TX_IDLE);
  assign bus.tx_done = tx_done_q;

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [11:0]     rx_baud_q, rx_baud_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_byte0_q, rx_byte0_d;
  logic            rx_have0_q, rx_have0_d;
  logic [GW-1:0]   rx_gap_q, rx_gap_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_rdy_q, rsp_rdy_d;
  logic            frm_err_q, frm_err_d;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // All three idle high so reset does not look like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte0_q <= '0;
      rx_have0_q <= 1'b0;
      rx_gap_q   <= '0;
      rsp_data_q <= '0;
      rsp_rdy_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte0_q <= rx_byte0_d;
      rx_have0_q <= rx_have0_d;
      rx_gap_q   <= rx_gap_d;
      rsp_data_q <= rsp_data_d;
      rsp_rdy_q  <= rsp_rdy_d;
      frm_err_q  <= frm_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte0_d = rx_byte0_q;
    rx_have0_d = rx_have0_q;
    rx_gap_d   = rx_gap_q;
    rsp_data_d = rsp_data_q;
    frm_err_d  = 1'b0;
    // A completion below overrides this, so a set beats a same-cycle clear.
    rsp_rdy_d  = bus.clr_rsp_rdy ? 1'b0 : rsp_rdy_q;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_baud_d  = '0;
        end else if (rx_have0_q) begin
          // Gap timer only runs while idle between byte 0 and byte 1.
          if (rx_gap_q == GAP_LAST) begin
            rx_have0_d = 1'b0;
            rx_gap_d   = '0;
            frm_err_d  = 1'b1;
          end else begin
            rx_gap_d = rx_gap_q + 1'b1;
          end
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d = '0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;   // line back high mid start bit: glitch
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
          end
        end else begin
          rx_baud_d = rx_baud_q + 12'd1;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_baud_d = rx_baud_q + 12'd1;
        end
      end
      RX_STOP: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_state_d = RX_IDLE;
          rx_gap_d   = '0;
          if (!rx_sync_q) begin
            frm_err_d  = 1'b1;
            rx_have0_d = 1'b0;
          end else if (!rx_have0_q) begin
            rx_byte0_d = rx_shift_q;
            rx_have0_d = 1'b1;
          end else begin
            rsp_data_d = {rx_byte0_q, rx_shift_q};
            rsp_rdy_d  = 1'b1;
            rx_have0_d = 1'b0;
          end
        end else begin
          rx_baud_d = rx_baud_q + 12'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_rdy  = rsp_rdy_q;
  assign bus.frm_err  = frm_err_q;

endmodule

// File: tb/tb_cmd_cfg_master.sv
// -----------------------------------------------------------------------------
// tb_cmd_cfg_master
// Directed bench for cmd_cfg_master with BAUD_DIV=16, GAP_BITS=20.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_cmd_cfg_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_cfg_master_if bus_if();

  cmd_cfg_master #(.BAUD_DIV(16), .GAP_BITS(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected TX level k clocks after the first start-bit cycle (16 clk/bit).
  function automatic logic exp_tx(input logic [23:0] p, input int k);
    int         bitpos;
    int         pos;
    logic [7:0] by;
    bitpos = k / 16;
    pos    = bitpos % 10;
    case (bitpos / 10)
      0:       by = p[23:16];
      1:       by = p[15:8];
      default: by = p[7:0];
    endcase
    if (pos == 0)      return 1'b0;
    else if (pos == 9) return 1'b1;
    else               return by[pos-1];
  endfunction

  // Send one packet and check it cycle by cycle. If inj_at >= 0 a second
  // send_cmd with all-ones data is pulsed at that packet cycle.
  task automatic tx_check(input string tag, input logic [23:0] pkt, input int inj_at);
    int bad_tx   = 0;
    int bad_busy = 0;
    int done_hi  = 0;
    int idle_bad = 0;
    bus_if.cmd_data = pkt;
    bus_if.send_cmd = 1'b1;
    step();
    bus_if.send_cmd = 1'b0;
    for (int k = 0; k < 480; k++) begin
      if (k == inj_at) begin
        bus_if.cmd_data = 24'hFFFFFF;
        bus_if.send_cmd = 1'b1;
      end else begin
        bus_if.send_cmd = 1'b0;
      end
      if (bus_if.TX !== exp_tx(pkt, k)) bad_tx++;
      if (bus_if.tx_busy !== 1'b1)      bad_busy++;
      if (bus_if.tx_done !== 1'b0)      done_hi++;
      step();
    end
    bus_if.send_cmd = 1'b0;
    check({tag, " tx bit errors"}, bad_tx, 0);
    check({tag, " busy low in packet"}, bad_busy, 0);
    check({tag, " early tx_done"}, done_hi, 0);
    check({tag, " tx_done at 480"}, bus_if.tx_done, 1);
    check({tag, " tx_busy at 480"}, bus_if.tx_busy, 0);
    check({tag, " TX idle at 480"}, bus_if.TX, 1);
    step();
    check({tag, " tx_done one cycle"}, bus_if.tx_done, 0);
    for (int k = 0; k < 40; k++) begin
      if (bus_if.TX !== 1'b1 || bus_if.tx_busy !== 1'b0) idle_bad++;
      step();
    end
    check({tag, " no second packet"}, idle_bad, 0);
  endtask

  // Drive one 8N1 frame on RX (160 clocks). clr_rsp_rdy is pulsed so that it
  // is sampled on the edge of frame clock clr_at+1. Counts frm_err cycles.
  task automatic rx_byte(input logic [7:0] b, input logic stop, input int clr_at,
                         output int errs);
    logic [9:0] fr;
    fr   = {stop, b, 1'b0};
    errs = 0;
    for (int k = 0; k < 160; k++) begin
      bus_if.RX          = fr[k/16];
      bus_if.clr_rsp_rdy = (k == clr_at);
      step();
      if (bus_if.frm_err === 1'b1) errs++;
    end
    bus_if.RX          = 1'b1;
    bus_if.clr_rsp_rdy = 1'b0;
  endtask

  task automatic clr_pulse();
    bus_if.clr_rsp_rdy = 1'b1;
    step();
    bus_if.clr_rsp_rdy = 1'b0;
  endtask

  initial begin
    int e1, e2, cnt, low_cnt, seen_at;

    // ---------------- reset ----------------
    rst                = 1'b1;
    bus_if.send_cmd    = 1'b0;
    bus_if.cmd_data    = '0;
    bus_if.RX          = 1'b1;
    bus_if.clr_rsp_rdy = 1'b0;
    repeat (3) step();
    check("rst TX", bus_if.TX, 1);
    check("rst tx_busy", bus_if.tx_busy, 0);
    check("rst tx_done", bus_if.tx_done, 0);
    check("rst rsp_rdy", bus_if.rsp_rdy, 0);
    check("rst frm_err", bus_if.frm_err, 0);
    check("rst rsp_data", bus_if.rsp_data, 16'h0000);
    rst = 1'b0;
    step();

    // ---------------- TX ----------------
    tx_check("txA", 24'hA53C0F, -1);
    tx_check("txB", 24'h817EC3, 100);

    // reset mid-packet at cycle 200 (TX low: byte 1 data bit 1 of all-zero)
    bus_if.cmd_data = 24'h000000;
    bus_if.send_cmd = 1'b1;
    step();
    bus_if.send_cmd = 1'b0;
    repeat (200) step();
    check("txR TX low before rst", bus_if.TX, 0);
    rst = 1'b1;
    step();
    check("txR TX after rst", bus_if.TX, 1);
    check("txR busy after rst", bus_if.tx_busy, 0);
    check("txR done after rst", bus_if.tx_done, 0);
    rst = 1'b0;
    cnt = 0;
    low_cnt = 0;
    for (int k = 0; k < 500; k++) begin
      step();
      if (bus_if.tx_done === 1'b1) cnt++;
      if (bus_if.TX !== 1'b1) low_cnt++;
    end
    check("txR no tx_done", cnt, 0);
    check("txR TX stays idle", low_cnt, 0);
    tx_check("txC", 24'h5AF096, -1);

    // ---------------- RX ----------------
    rx_byte(8'h12, 1'b1, -1, e1);
    rx_byte(8'h34, 1'b1, -1, e2);
    check("rx1 errs", e1 + e2, 0);
    check("rx1 rsp_data", bus_if.rsp_data, 16'h1234);
    check("rx1 rsp_rdy", bus_if.rsp_rdy, 1);
    clr_pulse();
    check("rx1 cleared", bus_if.rsp_rdy, 0);
    check("rx1 data kept", bus_if.rsp_data, 16'h1234);

    // clear coincident with completion: set wins
    rx_byte(8'hAA, 1'b1, -1, e1);
    check("rx2 rdy after byte0", bus_if.rsp_rdy, 0);
    rx_byte(8'h55, 1'b1, 154, e2);
    check("rx2 set beats clr", bus_if.rsp_rdy, 1);
    check("rx2 rsp_data", bus_if.rsp_data, 16'hAA55);

    // overwrite while rsp_rdy=1
    rx_byte(8'h9A, 1'b1, -1, e1);
    rx_byte(8'hBC, 1'b1, -1, e2);
    check("rx3 overwrite data", bus_if.rsp_data, 16'h9ABC);
    check("rx3 rdy held", bus_if.rsp_rdy, 1);
    clr_pulse();

    // 4-clock glitch must be rejected silently
    bus_if.RX = 1'b0;
    repeat (4) step();
    bus_if.RX = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus_if.frm_err === 1'b1) cnt++;
    end
    check("glitch frm_err", cnt, 0);
    check("glitch rsp_rdy", bus_if.rsp_rdy, 0);
    rx_byte(8'h56, 1'b1, -1, e1);
    rx_byte(8'h78, 1'b1, -1, e2);
    check("rx4 rsp_data", bus_if.rsp_data, 16'h5678);
    check("rx4 errs", e1 + e2, 0);
    clr_pulse();

    // bad stop on byte 0, then on byte 1 after a good byte 0
    rx_byte(8'hC3, 1'b0, -1, e1);
    check("stop0 frm_err pulses", e1, 1);
    check("stop0 rsp_rdy", bus_if.rsp_rdy, 0);
    repeat (16) step();
    rx_byte(8'hE1, 1'b1, -1, e1);
    rx_byte(8'hC3, 1'b0, -1, e2);
    check("stop1 frm_err pulses", e2, 1);
    check("stop1 rsp_rdy", bus_if.rsp_rdy, 0);
    repeat (16) step();
    rx_byte(8'h22, 1'b1, -1, e1);
    rx_byte(8'h33, 1'b1, -1, e2);
    check("stop1 partial discarded", bus_if.rsp_data, 16'h2233);
    clr_pulse();

    // gap timeout: stop sample is at frame clock 155, rx_byte returns at 160,
    // so the 320-clock timeout shows 315 clocks after the return.
    rx_byte(8'hAB, 1'b1, -1, e1);
    seen_at = -1;
    for (int n = 1; n <= 400 && seen_at < 0; n++) begin
      step();
      if (bus_if.frm_err === 1'b1) seen_at = n;
    end
    check("gap timeout time", seen_at, 315);
    step();
    check("gap frm_err one cycle", bus_if.frm_err, 0);
    check("gap rsp_rdy", bus_if.rsp_rdy, 0);
    rx_byte(8'h44, 1'b1, -1, e1);
    rx_byte(8'h55, 1'b1, -1, e2);
    check("gap byte0 discarded", bus_if.rsp_data, 16'h4455);
    check("gap new rdy", bus_if.rsp_rdy, 1);

    // reset discards a held byte 0
    rx_byte(8'h77, 1'b1, -1, e1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rxR rsp_data cleared", bus_if.rsp_data, 16'h0000);
    rx_byte(8'h88, 1'b1, -1, e1);
    rx_byte(8'h99, 1'b1, -1, e2);
    check("rxR fresh response", bus_if.rsp_data, 16'h8899);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_cfg_master.md
CMD_CFG_MASTER -- requirements
Module: cmd_cfg_master

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, meaning clocks per bit (800 MHz / 921,600 baud); legal range 8..4095.
REQ-002 SHALL have parameter GAP_BITS, default 20, meaning the idle bit-times after byte 0 before a partial response is discarded.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 send_cmd  input  1  one-cycle request to transmit cmd_data.
REQ-006 cmd_data  input  24  command packet; bits [23:16] sent first.
REQ-007 TX  output  1  serial command line to the device cfg receiver.
REQ-008 RX  input  1  serial response line from the device; asynchronous.
REQ-009 clr_rsp_rdy  input  1  clears rsp_rdy.
REQ-010 tx_busy  output  1  high while a command packet is in flight.
REQ-011 tx_done  output  1  one-cycle pulse at packet end.
REQ-012 rsp_data  output  16  last complete response; first received byte in [15:8].
REQ-013 rsp_rdy  output  1  high when a new rsp_data is valid.
REQ-014 frm_err  output  1  one-cycle pulse on a bad stop bit or a gap timeout.

Function
REQ-015 Frame format SHALL be 8N1: start 0, 8 data bits LSB first, stop 1; each bit lasts BAUD_DIV clocks.
REQ-016 The TX FSM SHALL use states IDLE, START, DATA, STOP and a 2-bit byte index.
REQ-017 In IDLE, send_cmd SHALL latch cmd_data, raise tx_busy the next cycle, and drive the first start bit that same cycle.
REQ-018 send_cmd while tx_busy=1 SHALL be ignored, and the latched data SHALL be unchanged.
REQ-019 The three bytes SHALL be sent back-to-back with no idle between a stop bit and the next start bit.
REQ-020 The packet SHALL take exactly 30*BAUD_DIV clocks from the first start-bit cycle to the end of the last stop bit.
REQ-021 At the end of the last stop bit, tx_done SHALL pulse for 1 cycle and tx_busy SHALL fall in the same cycle.
REQ-022 TX SHALL be 1 whenever the TX FSM is in IDLE.
REQ-023 RX SHALL pass through a 2-flop synchronizer; all RX decisions SHALL use the synchronized value.
REQ-024 The RX FSM SHALL use states IDLE, START, DATA, STOP.
REQ-025 In IDLE, a synchronized 1->0 transition SHALL enter START.
REQ-026 The start bit SHALL be resampled at BAUD_DIV/2 (integer divide); if it reads 1, the FSM SHALL return to IDLE with no error (glitch reject).
REQ-027 Data and stop bits SHALL each be sampled BAUD_DIV clocks after the previous sample.
REQ-028 Stop sampled 0 SHALL pulse frm_err, discard any partial response, reset the byte count to 0, and return the FSM to IDLE.
REQ-029 Stop sampled 1 on byte 0 SHALL hold that byte and start the gap counter.
REQ-030 Stop sampled 1 on byte 1 SHALL load rsp_data={byte0,byte1} and set rsp_rdy on the next cycle.
REQ-031 If no start edge occurs within GAP_BITS*BAUD_DIV clocks after byte 0, the FSM SHALL discard byte 0 and pulse frm_err.
REQ-032 rsp_rdy SHALL remain set until clr_rsp_rdy=1.
REQ-033 If clr_rsp_rdy and a response completion occur in the same cycle, the set SHALL win.
REQ-034 A new response arriving while rsp_rdy=1 SHALL overwrite rsp_data, and rsp_rdy SHALL stay 1.
REQ-035 The TX and RX paths SHALL operate fully independently and concurrently.

Reset
REQ-036 With rst=1 at a clock edge, the following SHALL hold on the next cycle: TX=1, tx_busy=0, tx_done=0, rsp_rdy=0, frm_err=0, rsp_data=16'h0000, both FSMs in IDLE, all counters 0.
REQ-037 Reset mid-packet SHALL abort the packet immediately: TX=1 on the next cycle, no tx_done pulse, and the partial RX byte discarded.
REQ-038 Synchronizer flops SHALL reset to 1.

Verification (BAUD_DIV=16)
REQ-039 send_cmd with cmd_data=24'hA5_3C_0F -> TX shows bytes A5, 3C, 0F LSB-first; tx_done fires 480 clocks after the start bit begins; tx_busy is high for the 480 cycles before that pulse.
REQ-040 send_cmd pulsed at cycle 100 of a packet with cmd_data=24'hFFFFFF -> the original packet completes unchanged; no second packet is sent.
REQ-041 RX driven with bytes 12, 34 -> rsp_data=16'h1234, rsp_rdy=1; clr_rsp_rdy pulse -> rsp_rdy=0; clr_rsp_rdy coincident with the next completion -> rsp_rdy=1.
REQ-042 RX low for 4 clocks then high -> no byte received, no frm_err; a following valid response of 56, 78 -> rsp_data=16'h5678.
REQ-043 Byte 0 received with stop=0 -> frm_err pulse, rsp_rdy stays 0; byte AB then 400 idle clocks -> frm_err at 320 clocks after byte 0's stop sample.
REQ-044 rst asserted at cycle 200 of a TX packet -> TX=1 next cycle, no tx_done; a following send_cmd sends a full 30-bit packet.
